wptr_full: RTL and testbench

// - Write-domain pointer and full-flag generator for the dual-clock FIFO; sits directly upstream of the FIFO memory.
// - Accepts write requests and drives the memory write address and write enable.
// - Produces the Gray-coded write pointer that is synchronised into the read domain.
// - Compares against the synchronised read pointer to assert full, and flags overflow attempts.

---
 rtl/wptr_full.sv | 75 +++++++
 tb/tb_wptr_full.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/wptr_full.sv
// Write-domain pointer / full-flag generator for the dual-clock FIFO.
// Optional almost-full logic is built when WPTR_FULL_ALMOST_FULL_EN is defined.
module wptr_full #(
    parameter int ASIZE    = 4,
    parameter int AF_LEVEL = 12
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic [ASIZE:0]   wq2_rptr,
    input  logic             wovf_clr,
    output logic [ASIZE-1:0] waddr,
    output logic             wclken,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic             woverflow,
    output logic             wafull
);

    if (ASIZE < 2 || AF_LEVEL < 1 || AF_LEVEL > (1 << ASIZE)) begin : g_param_chk
        $error("wptr_full: ASIZE must be >= 2 and AF_LEVEL in 1..DEPTH");
    end

    logic [ASIZE:0] wbin, wbinnext, wgraynext;
    logic           wfull_next;

    assign waddr     = wbin[ASIZE-1:0];
    assign wclken    = winc & ~wfull;
    assign wbinnext  = wbin + {{ASIZE{1'b0}}, wclken};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;
    // Full when the next write pointer has lapped the read pointer: top two Gray bits inverted.
    assign wfull_next = (wgraynext == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin      <= '0;
            wptr      <= '0;
            wfull     <= 1'b0;
            woverflow <= 1'b0;
        end else begin
            wbin  <= wbinnext;
            wptr  <= wgraynext;
            wfull <= wfull_next;
            if (winc && wfull)
                woverflow <= 1'b1;
            else if (wovf_clr)
                woverflow <= 1'b0;
        end
    end

`ifdef WPTR_FULL_ALMOST_FULL_EN
    localparam logic [ASIZE:0] AF_THR = (ASIZE+1)'(AF_LEVEL);

    logic [ASIZE:0] rbin, fill;

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ASIZE; i++)
            rbin[i] = ^(wq2_rptr >> i);
    end

    // Modular difference: a full FIFO yields exactly DEPTH, which fits in ASIZE+1 bits.
    assign fill = wbinnext - rbin;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst)
            wafull <= 1'b0;
        else
            wafull <= (fill >= AF_THR);
    end
`else
    assign wafull = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full.sv
// Randomized + directed bench for wptr_full against an occupancy-count model.
// Define WPTR_FULL_ALMOST_FULL_EN for both files to exercise wafull.
module tb_wptr_full;
    localparam int ASIZE    = 4;
    localparam int DEPTH    = 1 << ASIZE;
    localparam int PMOD     = 2 * DEPTH;
    localparam int AF_LEVEL = 12;

    logic             wclk = 1'b0;
    logic             wrst = 1'b1;
    logic             winc = 1'b0;
    logic [ASIZE:0]   wq2_rptr = '0;
    logic             wovf_clr = 1'b0;
    logic [ASIZE-1:0] waddr;
    logic             wclken;
    logic [ASIZE:0]   wptr;
    logic             wfull;
    logic             woverflow;
    logic             wafull;

    wptr_full #(.ASIZE(ASIZE), .AF_LEVEL(AF_LEVEL)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr),
        .wovf_clr(wovf_clr), .waddr(waddr), .wclken(wclken), .wptr(wptr),
        .wfull(wfull), .woverflow(woverflow), .wafull(wafull)
    );

    always #5 wclk = ~wclk;

    // Model: counts of writes accepted and reads seen, plus flag state.
    int m_wcnt, m_rcnt;
    bit m_full, m_ovf, m_af;
    int checks = 0, failures = 0;

    function automatic int gray(input int x);
        return (x ^ (x >> 1)) & (PMOD - 1);
    endfunction

    function automatic int occ();
        return (m_wcnt - m_rcnt + PMOD) % PMOD;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_regs();
        chk("waddr", 32'(waddr), 32'(m_wcnt % DEPTH));
        chk("wptr", 32'(wptr), 32'(gray(m_wcnt)));
        chk("wfull", 32'(wfull), 32'(m_full));
        chk("woverflow", 32'(woverflow), 32'(m_ovf));
        chk("wafull", 32'(wafull), 32'(m_af));
    endtask

    // One write-clock cycle: drive, check combinational enable, clock, check registers.
    task automatic step(input bit w, input int rc, input bit clr);
        bit acc;
        winc = w; wovf_clr = clr;
        m_rcnt = rc % PMOD;
        wq2_rptr = (ASIZE+1)'(gray(m_rcnt));
        #1;
        chk("wclken", 32'(wclken), 32'(w & ~m_full));
        @(posedge wclk);
        acc = w & ~m_full;
        if (w && m_full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_wcnt = (m_wcnt + int'(acc)) % PMOD;
        m_full = (occ() == DEPTH);
`ifdef WPTR_FULL_ALMOST_FULL_EN
        m_af = (occ() >= AF_LEVEL);
`else
        m_af = 1'b0;
`endif
        #1;
        chk_regs();
    endtask

    task automatic do_reset();
        wrst = 1'b1; winc = 1'b1; wovf_clr = 1'b0; wq2_rptr = '0;
        m_wcnt = 0; m_rcnt = 0; m_full = 0; m_ovf = 0; m_af = 0;
        #1;
        chk_regs();
        chk("rst_wclken", 32'(wclken), 32'd1);
        @(negedge wclk);
        wrst = 1'b0;
    endtask

    initial begin
        int rc;
        do_reset();

        // Fill to full
        for (int i = 0; i < DEPTH; i++) step(1'b1, 0, 1'b0);
        chk("fill_wptr", 32'(wptr), 32'b11000);
        chk("fill_full", 32'(wfull), 32'd1);

        // Overflow then clear
        for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b0);
        chk("ovf_set", 32'(woverflow), 32'd1);
        chk("ovf_addr", 32'(waddr), 32'd0);
        step(1'b0, 0, 1'b1);
        chk("ovf_clr", 32'(woverflow), 32'd0);

        // Drain and wrap
        step(1'b0, 16, 1'b0);
        chk("drain_full", 32'(wfull), 32'd0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 16, 1'b0);
        chk("wrap_wptr", 32'(wptr), 32'd0);
        chk("wrap_full", 32'(wfull), 32'd1);

        // Overflow and clear in the same cycle: set wins
        step(1'b1, 16, 1'b1);
        chk("ovf_setwins", 32'(woverflow), 32'd1);

        // Almost-full threshold
        do_reset();
        for (int i = 0; i < AF_LEVEL - 1; i++) step(1'b1, 0, 1'b0);
        chk("af_below", 32'(wafull), 32'd0);
        step(1'b1, 0, 1'b0);
`ifdef WPTR_FULL_ALMOST_FULL_EN
        chk("af_at", 32'(wafull), 32'd1);
`else
        chk("af_at", 32'(wafull), 32'd0);
`endif

        // Asynchronous reset mid-fill
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 0, 1'b0);
        @(negedge wclk);
        wrst = 1'b1; winc = 1'b0;
        m_wcnt = 0; m_rcnt = 0; m_full = 0; m_ovf = 0; m_af = 0;
        #1;
        chk_regs();
        @(negedge wclk);
        wrst = 1'b0;
        step(1'b1, 0, 1'b0);
        chk("post_rst_addr", 32'(waddr), 32'd1);

        // Randomized traffic with a read pointer that trails the writes
        do_reset();
        rc = 0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 2) == 0)
                rc = (rc + int'($urandom_range(0, occ()))) % PMOD;
            step(($urandom_range(0, 3) != 0), rc, ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
